// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch unit and the instruction decoder/controller
// of the single-cycle MIPS core.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;

  localparam int WORD_BYTES = 4;

  // Primary opcodes; OP_MUL is the SPECIAL2 group, OP_NP the reserved no-op slot.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_MUL   = 6'h1c;
  localparam logic [5:0] OP_NP    = 6'h3f;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter for an outstanding fetch; hit is high once the
// count has reached TIMEOUT-1.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign hit = (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake,
// holds the instruction for the decoder and applies the next-PC decision.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fetch_err
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_next;
  logic         fetch_err_next;
  logic         capture;
  logic         wait_hit;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != REQ) || imem_ready),
    .en    ((state == REQ) && !imem_ready),
    .hit   (wait_hit)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    fetch_err_next = fetch_err;
    capture        = 1'b0;
    case (state)
      BOOT: state_next = REQ;
      REQ: begin
        if (imem_ready) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else if (wait_hit) begin
          fetch_err_next = 1'b1;
          state_next     = HALT;
        end
      end
      HOLD: begin
        // Control inputs only matter once the datapath releases the instruction.
        if (!stall) begin
          if (halt) begin
            state_next = HALT;
          end else if (redirect) begin
            if (!word_aligned(redirect_pc)) begin
              fetch_err_next = 1'b1;
              state_next     = HALT;
            end else begin
              pc_next    = redirect_pc;
              state_next = REQ;
            end
          end else begin
            pc_next    = pc_plus4;
            state_next = REQ;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      instr     <= '0;
      fetch_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      fetch_err <= fetch_err_next;
      halted    <= (state_next == HALT);
      if (capture) begin
        instr <= imem_rdata;
      end
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign pc_plus4    = pc + 32'(WORD_BYTES);
  assign op          = instr[OP_MSB:OP_LSB];
  assign funct       = instr[FUNCT_MSB:0];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder/controller in the single-cycle MIPS core.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Holds each returned 32-bit instruction stable and exposes op/funct fields to the decoder.
- Applies the next-PC decision (sequential, branch or jump target) when the datapath releases the current instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT, 16, maximum cycles to wait for imem_ready before flagging an error (range 2..255).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; equals pc.
- imem_ready  in  1  memory response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  datapath is not yet done with the held instruction.
- redirect  in  1  take redirect_pc instead of pc+4; the datapath drives this as PCSrc|Jump.
- redirect_pc  in  32  branch or jump target.
- halt  in  1  stop fetching after the held instruction retires.
- instr  out  32  held instruction.
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- instr_valid  out  1  instr, op and funct are valid.
- pc  out  32  address of the held or requested instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- halted  out  1  FSM is in HALT.
- fetch_err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0, halted = 0, fetch_err = 0, timeout counter = 0, state = BOOT.
- Reset asserted mid-request abandons the request with no handshake; a late imem_ready after reset is ignored until the FSM is in REQ.
- FSM states: BOOT, REQ, HOLD, HALT.
- BOOT: lasts one cycle after rst_n deasserts, then goes to REQ.
- REQ:
  - Outputs: imem_req = 1, imem_addr = pc, instr_valid = 0.
  - The counter increments each cycle imem_ready is low.
  - On imem_ready: instr <= imem_rdata, counter cleared, state goes to HOLD, and instr_valid = 1 from the next cycle.
  - If the counter reaches TIMEOUT-1 with no ready: fetch_err <= 1 and state goes to HALT.
- Latency and throughput:
  - Minimum latency is request to instr_valid = 1 cycle when ready is returned in the request cycle.
  - Peak throughput is one instruction every 2 cycles.
- imem_addr and imem_req are held stable while imem_req = 1 and imem_ready = 0.
- HOLD:
  - Outputs: instr_valid = 1, instr held, imem_req = 0.
  - If stall = 1: remain in HOLD; redirect and halt are ignored.
  - If stall = 0 and halt = 1: go to HALT with pc unchanged; halt has priority over redirect.
  - If stall = 0 and redirect = 1:
    - redirect_pc[1:0] != 0: fetch_err <= 1 and go to HALT.
    - Otherwise: pc <= redirect_pc and go to REQ.
  - If stall = 0 and neither halt nor redirect: pc <= pc_plus4 (0xFFFF_FFFC wraps to 0x0000_0000) and go to REQ.
- HALT:
  - Outputs: halted = 1, instr_valid = 0, imem_req = 0.
  - Left only by reset.
- redirect, redirect_pc and halt are sampled only in HOLD with stall = 0; in any other state they have no effect.
- fetch_err and halted are registered outputs. pc_plus4, op and funct are combinational from pc and instr.

Decomposition:
- Shared package (cpu_pkg):
  - State enum: BOOT, REQ, HOLD, HALT.
  - Field slice constants: OP_MSB = 31, OP_LSB = 26, FUNCT_MSB = 5.
  - Opcode constants shared with the controller: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_MUL, OP_NP.
  - Word size WORD_BYTES = 4.
- One natural sub-module: fetch_timeout_ctr, a saturating wait counter with clear/enable inputs and a hit output at TIMEOUT-1.

Test Plan:
- Reset, then a zero-wait memory returning 0x2008_0005 at 0x0: imem_req rises one cycle after reset release with imem_addr = 0x0. One cycle later: instr_valid = 1, op = 6'b001000, funct = 6'b000101.
- Sequential fetch with stall held 3 cycles in HOLD: instr stays constant for those cycles. After stall drops, the next request is at 0x4 and pc_plus4 = 0x8.
- Branch: in HOLD with redirect = 1, redirect_pc = 0x40: the next imem_addr is 0x40. A second redirect to 0x42 sets fetch_err = 1 and halted = 1, and imem_req stays 0 afterwards.
- Slow memory: with TIMEOUT = 16, ready after 5 wait cycles gives a normal capture. No ready for 16 cycles sets fetch_err = 1 and the FSM enters HALT.
- Wrap and halt:
  - pc = 0xFFFF_FFFC with stall = 0, no redirect: the next imem_addr is 0x0.
  - halt and redirect both asserted in HOLD: the FSM goes to HALT with pc unchanged.
- Asynchronous reset asserted mid-REQ, between clock edges: outputs clear immediately. A stale imem_ready pulse during BOOT does not change instr.
